kip_local_formatter_pipelined: RTL and testbench
================================================

Name: kip_local_formatter_pipelined

Overview:
Successor to the combinational KIP local formatter. It sits between the KIP router and the local kernel AXIS fabric. It captures the sender TID and destination TID from the header (first) beat of each packet and holds both on tid/tdest for every beat of that packet. It can optionally drop packets whose destination lies outside the local kernel range, and it registers the datapath through a 2-entry skid buffer for timing closure.

Parameters:
AXIS_DATA_WIDTH, 512, data bus width (multiple of 8)
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, keep width
AXIS_TUSER_WIDTH, 16, tuser width, passed through unchanged
AXIS_TID_WIDTH, 8, width of the tid/tdest fields
SENDER_TID_OFFSET, 0, bit offset of the sender TID in the header beat
DEST_TID_OFFSET, 8, bit offset of the destination TID in the header beat
FILTER_EN, 0, 1 = drop packets with non-local destination
LOCAL_TID_BASE, 0, first local destination TID
LOCAL_TID_COUNT, 2**AXIS_TID_WIDTH, number of local TIDs; 0 means drop all when filtering
DROP_CNT_WIDTH, 32, width of the drop counter

Ports:
i_clk  in  1  clock
i_ap_rst_n  in  1  asynchronous active-low reset
from_router_tvalid  in  1  AXIS valid from router
from_router_tready  out  1  AXIS ready to router
from_router_tdata  in  AXIS_DATA_WIDTH  data
from_router_tkeep  in  AXIS_KEEP_WIDTH  keep
from_router_tuser  in  AXIS_TUSER_WIDTH  user
from_router_tlast  in  1  last
to_kernels_tvalid  out  1  AXIS valid to kernels
to_kernels_tready  in  1  AXIS ready from kernels
to_kernels_tdata  out  AXIS_DATA_WIDTH  data
to_kernels_tkeep  out  AXIS_KEEP_WIDTH  keep
to_kernels_tid  out  AXIS_TID_WIDTH  sender TID, held for the whole packet
to_kernels_tdest  out  AXIS_TID_WIDTH  destination TID, held for the whole packet
to_kernels_tuser  out  AXIS_TUSER_WIDTH  user
to_kernels_tlast  out  1  last
drop_count  out  DROP_CNT_WIDTH  packets dropped since reset, saturating

Behaviour:
- Reset: asynchronous assert and synchronous-release effect on all state.
  - Outputs during reset: all to_kernels_* = 0, from_router_tready = 0, drop_count = 0, FSM = HEAD, skid buffer empty.
  - from_router_tready rises in the first cycle after deassertion.
- Input handshake:
  - A beat transfers when tvalid && tready.
  - from_router_tready = !skid_full, registered; it is also forced to 1 in DROP and when a header beat will be dropped.
- FSM states: HEAD, BODY, DROP.
- HEAD, on an accepted beat:
  - Extract s = tdata[SENDER_TID_OFFSET +: AXIS_TID_WIDTH] and d = tdata[DEST_TID_OFFSET +: AXIS_TID_WIDTH].
  - Local check: d >= LOCAL_TID_BASE && d < LOCAL_TID_BASE + LOCAL_TID_COUNT, evaluated at AXIS_TID_WIDTH+2 bits so the sum cannot overflow.
  - If FILTER_EN = 1 and the check fails: beat discarded; drop_count += 1 unless already all-ones; next = tlast ? HEAD : DROP.
  - Otherwise: latch s/d into the held tid/tdest registers; push the beat into the skid buffer tagged with s/d; next = tlast ? HEAD : BODY.
- BODY, on an accepted beat: push the beat tagged with the held s/d; return to HEAD on tlast.
- DROP: tready = 1; discard beats; return to HEAD on an accepted tlast. drop_count does not change in DROP.
- Skid buffer:
  - 2 entries; latency 1 cycle from input accept to to_kernels_tvalid.
  - Sustains 1 beat/cycle when to_kernels_tready = 1.
  - No combinational path from to_kernels_tready to from_router_tready.
- Output rules:
  - tdata, tkeep, tuser and tlast pass through unchanged.
  - Output fields stay stable while tvalid = 1 and tready = 0 (AXIS rule).
- Single-beat packets (tlast on header) stay in HEAD.
- Back-to-back packets: a header immediately after tlast is processed in the same cycle as any other beat, with no bubble.
- Reset mid-packet: all state is flushed. The next accepted beat is treated as a header; there is no resynchronisation.
- FILTER_EN = 0: drop_count stays 0 and every packet is forwarded.

Test Plan:
- Reset, then a 3-beat packet with header s = 0x05, d = 0x12, to_kernels_tready = 1 -> 3 output beats, each with tid = 0x05 and tdest = 0x12; first output beat 1 cycle after the header is accepted; tlast only on beat 3.
- Continuous stream of 1-beat packets with d = 0,1,2…, ready always high -> one output per cycle and the tdest sequence matches.
- FILTER_EN = 1, BASE = 0x10, COUNT = 4; packets with d = 0x0F, 0x10, 0x13, 0x14 -> only 0x10 and 0x13 are forwarded; drop_count = 2; dropped beats are accepted at 1 per cycle.
- to_kernels_tready toggled 0/1 at random over a 64-beat stream -> no data loss or duplication; outputs hold while stalled; from_router_tready falls only when both skid entries are full.
- Reset asserted on beat 2 of a 4-beat packet -> to_kernels_tvalid = 0 immediately; after release, the next beat with d = 0x33 is forwarded with tdest = 0x33.
- drop_count preloaded near saturation, with DROP_CNT_WIDTH = 2 and 5 non-local packets -> drop_count reads 3 and holds at 3.

Source files
------------

// File: rtl/kip_local_formatter_pipelined.sv
// KIP local formatter: tags every beat of a packet with the sender/destination TIDs taken
// from its header beat, optionally drops non-local packets, and registers the stream in a 2-entry skid buffer.
module kip_local_formatter_pipelined #(
   parameter int AXIS_DATA_WIDTH   = 512,
   parameter int AXIS_KEEP_WIDTH   = AXIS_DATA_WIDTH / 8,
   parameter int AXIS_TUSER_WIDTH  = 16,
   parameter int AXIS_TID_WIDTH    = 8,
   parameter int SENDER_TID_OFFSET = 0,
   parameter int DEST_TID_OFFSET   = 8,
   parameter int FILTER_EN         = 0,
   parameter int LOCAL_TID_BASE    = 0,
   parameter int LOCAL_TID_COUNT   = 2 ** AXIS_TID_WIDTH,
   parameter int DROP_CNT_WIDTH    = 32
) (
   input  logic                        i_clk,
   input  logic                        i_ap_rst_n,
   input  logic                        from_router_tvalid,
   output logic                        from_router_tready,
   input  logic [AXIS_DATA_WIDTH-1:0]  from_router_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0]  from_router_tkeep,
   input  logic [AXIS_TUSER_WIDTH-1:0] from_router_tuser,
   input  logic                        from_router_tlast,
   output logic                        to_kernels_tvalid,
   input  logic                        to_kernels_tready,
   output logic [AXIS_DATA_WIDTH-1:0]  to_kernels_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0]  to_kernels_tkeep,
   output logic [AXIS_TID_WIDTH-1:0]   to_kernels_tid,
   output logic [AXIS_TID_WIDTH-1:0]   to_kernels_tdest,
   output logic [AXIS_TUSER_WIDTH-1:0] to_kernels_tuser,
   output logic                        to_kernels_tlast,
   output logic [DROP_CNT_WIDTH-1:0]   drop_count,
   output logic [1:0]                  dbg_state_o
);

   // Handshake: a beat moves on either side only in a cycle where valid && ready; valid never
   // waits on ready, and once valid is high the beat's fields hold until it is taken.
   typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, DROP = 2'd2} state_e;

   localparam int EXT_W = AXIS_TID_WIDTH + 2;
   localparam logic [EXT_W-1:0] LOCAL_LO = EXT_W'(LOCAL_TID_BASE);
   localparam logic [EXT_W-1:0] LOCAL_HI = EXT_W'(LOCAL_TID_BASE + LOCAL_TID_COUNT);

   state_e                      state_q;
   logic                        live_q;
   logic                        rdy_q;
   logic [AXIS_TID_WIDTH-1:0]   tid_q;
   logic [AXIS_TID_WIDTH-1:0]   tdest_q;
   logic [DROP_CNT_WIDTH-1:0]   drop_cnt_q;

   logic [AXIS_DATA_WIDTH-1:0]  data_q  [2];
   logic [AXIS_KEEP_WIDTH-1:0]  keep_q  [2];
   logic [AXIS_TUSER_WIDTH-1:0] user_q  [2];
   logic                        last_q  [2];
   logic [AXIS_TID_WIDTH-1:0]   etid_q  [2];
   logic [AXIS_TID_WIDTH-1:0]   edest_q [2];
   logic                        wr_q;
   logic                        rd_q;
   logic [1:0]                  cnt_q;
   logic [1:0]                  cnt_d;

   logic [AXIS_TID_WIDTH-1:0]   s_in;
   logic [AXIS_TID_WIDTH-1:0]   d_in;
   logic [EXT_W-1:0]            d_ext;
   logic                        is_local;
   logic                        hdr_drop;
   logic                        in_ready;
   logic                        accept;
   logic                        drop_beat;
   logic                        push;
   logic                        pop;
   logic [AXIS_TID_WIDTH-1:0]   push_tid;
   logic [AXIS_TID_WIDTH-1:0]   push_tdest;

   always_comb begin
      s_in       = from_router_tdata[SENDER_TID_OFFSET +: AXIS_TID_WIDTH];
      d_in       = from_router_tdata[DEST_TID_OFFSET +: AXIS_TID_WIDTH];
      d_ext      = {2'b00, d_in};
      is_local   = (d_ext >= LOCAL_LO) && (d_ext < LOCAL_HI);
      hdr_drop   = (FILTER_EN != 0) && !is_local;
      // Discarded beats never enter the buffer, so they may be taken even while it is full.
      in_ready   = live_q && (rdy_q || (state_q == DROP) || ((state_q == HEAD) && hdr_drop));
      accept     = from_router_tvalid && in_ready;
      drop_beat  = accept && ((state_q == DROP) || ((state_q == HEAD) && hdr_drop));
      push       = accept && !drop_beat;
      pop        = (cnt_q != 2'd0) && to_kernels_tready;
      push_tid   = (state_q == HEAD) ? s_in : tid_q;
      push_tdest = (state_q == HEAD) ? d_in : tdest_q;
      cnt_d      = cnt_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         state_q    <= HEAD;
         tid_q      <= '0;
         tdest_q    <= '0;
         drop_cnt_q <= '0;
      end else if (accept) begin
         case (state_q)
            HEAD: begin
               if (drop_beat) begin
                  if (drop_cnt_q != {DROP_CNT_WIDTH{1'b1}}) begin
                     drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
                  end
                  state_q <= from_router_tlast ? HEAD : DROP;
               end else begin
                  tid_q   <= s_in;
                  tdest_q <= d_in;
                  state_q <= from_router_tlast ? HEAD : BODY;
               end
            end
            BODY:    state_q <= from_router_tlast ? HEAD : BODY;
            DROP:    state_q <= from_router_tlast ? HEAD : DROP;
            default: state_q <= HEAD;
         endcase
      end
   end

   // Ready is taken from the next occupancy, so downstream ready never reaches upstream combinationally.
   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         live_q <= 1'b0;
         rdy_q  <= 1'b0;
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         cnt_q  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            data_q[i]  <= '0;
            keep_q[i]  <= '0;
            user_q[i]  <= '0;
            last_q[i]  <= 1'b0;
            etid_q[i]  <= '0;
            edest_q[i] <= '0;
         end
      end else begin
         live_q <= 1'b1;
         rdy_q  <= (cnt_d != 2'd2);
         cnt_q  <= cnt_d;
         if (push) begin
            data_q[wr_q]  <= from_router_tdata;
            keep_q[wr_q]  <= from_router_tkeep;
            user_q[wr_q]  <= from_router_tuser;
            last_q[wr_q]  <= from_router_tlast;
            etid_q[wr_q]  <= push_tid;
            edest_q[wr_q] <= push_tdest;
            wr_q          <= !wr_q;
         end
         if (pop) begin
            rd_q <= !rd_q;
         end
      end
   end

   assign from_router_tready = in_ready;
   assign to_kernels_tvalid  = (cnt_q != 2'd0);
   assign to_kernels_tdata   = data_q[rd_q];
   assign to_kernels_tkeep   = keep_q[rd_q];
   assign to_kernels_tuser   = user_q[rd_q];
   assign to_kernels_tlast   = last_q[rd_q];
   assign to_kernels_tid     = etid_q[rd_q];
   assign to_kernels_tdest   = edest_q[rd_q];
   assign drop_count         = drop_cnt_q;
   assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_kip_local_formatter_pipelined.sv
// Bench for kip_local_formatter_pipelined: one unfiltered and one filtered instance
// (base 0x10, count 4, 2-bit drop counter), checked against a packet-level model.
module tb_kip_local_formatter_pipelined;
   localparam int DW    = 64;
   localparam int KW    = DW / 8;
   localparam int UW    = 16;
   localparam int TW    = 8;
   localparam int EW    = DW + KW + UW + 1 + TW + TW;
   localparam int BASE1 = 16;
   localparam int CNT1  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid [2];
   logic          in_ready [2];
   logic [DW-1:0] in_data  [2];
   logic [KW-1:0] in_keep  [2];
   logic [UW-1:0] in_user  [2];
   logic          in_last  [2];
   logic          out_valid[2];
   logic          out_ready[2];
   logic [DW-1:0] out_data [2];
   logic [KW-1:0] out_keep [2];
   logic [TW-1:0] out_tid  [2];
   logic [TW-1:0] out_dest [2];
   logic [UW-1:0] out_user [2];
   logic          out_last [2];
   logic [31:0]   drop0;
   logic [1:0]    drop1;
   logic [1:0]    dbg0;
   logic [1:0]    dbg1;

   kip_local_formatter_pipelined #(
      .AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .AXIS_TID_WIDTH(TW), .FILTER_EN(0)
   ) u_nofilt (
      .i_clk(clk), .i_ap_rst_n(rst_n),
      .from_router_tvalid(in_valid[0]), .from_router_tready(in_ready[0]),
      .from_router_tdata(in_data[0]), .from_router_tkeep(in_keep[0]),
      .from_router_tuser(in_user[0]), .from_router_tlast(in_last[0]),
      .to_kernels_tvalid(out_valid[0]), .to_kernels_tready(out_ready[0]),
      .to_kernels_tdata(out_data[0]), .to_kernels_tkeep(out_keep[0]),
      .to_kernels_tid(out_tid[0]), .to_kernels_tdest(out_dest[0]),
      .to_kernels_tuser(out_user[0]), .to_kernels_tlast(out_last[0]),
      .drop_count(drop0), .dbg_state_o(dbg0)
   );

   kip_local_formatter_pipelined #(
      .AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .AXIS_TID_WIDTH(TW), .FILTER_EN(1),
      .LOCAL_TID_BASE(BASE1), .LOCAL_TID_COUNT(CNT1), .DROP_CNT_WIDTH(2)
   ) u_filt (
      .i_clk(clk), .i_ap_rst_n(rst_n),
      .from_router_tvalid(in_valid[1]), .from_router_tready(in_ready[1]),
      .from_router_tdata(in_data[1]), .from_router_tkeep(in_keep[1]),
      .from_router_tuser(in_user[1]), .from_router_tlast(in_last[1]),
      .to_kernels_tvalid(out_valid[1]), .to_kernels_tready(out_ready[1]),
      .to_kernels_tdata(out_data[1]), .to_kernels_tkeep(out_keep[1]),
      .to_kernels_tid(out_tid[1]), .to_kernels_tdest(out_dest[1]),
      .to_kernels_tuser(out_user[1]), .to_kernels_tlast(out_last[1]),
      .drop_count(drop1), .dbg_state_o(dbg1)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];
   int exp_drop1 = 0;
   bit cur_fwd[2];
   bit fix_ready[2];
   bit rnd_mode[2];
   int out_cnt[2];
   int inflight[2];
   int since_rst[2];
   bit prev_hold[2];
   logic [EW-1:0] prev_obs[2];

   task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int sel, input logic [EW-1:0] v);
      if (sel == 0) exp_q0.push_back(v);
      else exp_q1.push_back(v);
   endtask

   task automatic pop_exp(input int sel, output bit ok, output logic [EW-1:0] v);
      v = '0;
      if (sel == 0) begin
         ok = (exp_q0.size() != 0);
         if (ok) v = exp_q0.pop_front();
      end else begin
         ok = (exp_q1.size() != 0);
         if (ok) v = exp_q1.pop_front();
      end
   endtask

   function automatic int exp_size(input int sel);
      return (sel == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         out_ready[i] = rnd_mode[i] ? 1'($urandom_range(0, 1)) : fix_ready[i];
      end
   end

   // Scoreboard and stream-rule monitor, sampled on the falling edge.
   always @(negedge clk) begin
      logic [EW-1:0] obs;
      logic [EW-1:0] e;
      bit ok;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            prev_hold[i] = 1'b0;
            inflight[i]  = 0;
            since_rst[i] = 0;
         end else begin
            since_rst[i]++;
            obs = {out_data[i], out_keep[i], out_user[i], out_last[i], out_tid[i], out_dest[i]};
            if (prev_hold[i])
               check(out_valid[i] && (obs == prev_obs[i]), "stall_hold", obs, prev_obs[i]);
            if (since_rst[i] >= 2 && !in_ready[i])
               check(inflight[i] == 2, "tready_low_not_full", 128'(inflight[i]), 128'd2);
            if (out_valid[i] && out_ready[i]) begin
               pop_exp(i, ok, e);
               check(ok, "unexpected_beat", obs, 128'd0);
               if (ok) check(obs == e, "out_beat", obs, e);
               out_cnt[i]++;
               inflight[i]--;
            end
            if (in_valid[i] && in_ready[i] && cur_fwd[i]) inflight[i]++;
            prev_hold[i] = out_valid[i] && !out_ready[i];
            prev_obs[i]  = obs;
         end
      end
   end

   task automatic send_beat(input int sel, input logic [DW-1:0] data, input logic [KW-1:0] keep,
                            input logic [UW-1:0] user, input logic last);
      bit got;
      in_data[sel]  = data;
      in_keep[sel]  = keep;
      in_user[sel]  = user;
      in_last[sel]  = last;
      in_valid[sel] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk);
         if (in_ready[sel]) got = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid[sel] = 1'b0;
      if (!got) check(1'b0, "send_timeout", 128'(sel), 128'd1);
   endtask

   // Packet-level model: a packet is forwarded whole with its header TIDs, or dropped whole.
   task automatic send_packet(input int sel, input logic [7:0] s, input logic [7:0] d, input int n, input bit gaps);
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic last;
      bit fwd;
      fwd = (sel == 0) || ((int'(d) >= BASE1) && (int'(d) < BASE1 + CNT1));
      cur_fwd[sel] = fwd;
      if (!fwd && exp_drop1 < 3) exp_drop1++;
      for (int b = 0; b < n; b++) begin
         data = {$urandom, $urandom};
         keep = KW'($urandom);
         user = UW'($urandom);
         last = (b == n - 1);
         if (b == 0) begin
            data[7:0]  = s;
            data[15:8] = d;
         end
         if (fwd) push_exp(sel, {data, keep, user, last, s, d});
         send_beat(sel, data, keep, user, last);
         if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic drain(input int sel);
      int k;
      k = 0;
      while (exp_size(sel) != 0 && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (2) begin @(posedge clk); #1; end
      check(exp_size(sel) == 0, "drain", 128'(exp_size(sel)), 128'd0);
   endtask

   typedef struct {
      logic [7:0] d;
      int nbeats;
      int fwd_beats;
      int drop;
      int cycles;
   } vec_t;

   initial begin
      vec_t tbl[10];
      logic [DW-1:0] bd[3];
      logic [KW-1:0] bk[3];
      logic [UW-1:0] bu[3];
      int o, c, beats, n;
      logic [7:0] dd;

      tbl[0] = '{8'h0F, 1, 0, 1, 1};
      tbl[1] = '{8'h10, 1, 1, 1, 1};
      tbl[2] = '{8'h13, 2, 2, 1, 2};
      tbl[3] = '{8'h14, 4, 0, 2, 4};
      tbl[4] = '{8'h00, 3, 0, 3, 3};
      tbl[5] = '{8'hFF, 1, 0, 3, 1};
      tbl[6] = '{8'h11, 2, 2, 3, 2};
      tbl[7] = '{8'h50, 1, 0, 3, 1};
      tbl[8] = '{8'h20, 2, 0, 3, 2};
      tbl[9] = '{8'h0E, 1, 0, 3, 1};

      for (int i = 0; i < 2; i++) begin
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         in_keep[i]   = '0;
         in_user[i]   = '0;
         in_last[i]   = 1'b0;
         out_ready[i] = 1'b1;
         fix_ready[i] = 1'b1;
         rnd_mode[i]  = 1'b0;
         cur_fwd[i]   = 1'b1;
         out_cnt[i]   = 0;
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check(out_valid[i] == 1'b0, "rst_tvalid", 128'(out_valid[i]), 128'd0);
         check(in_ready[i] == 1'b0, "rst_tready", 128'(in_ready[i]), 128'd0);
         check({out_data[i], out_keep[i], out_user[i], out_last[i], out_tid[i], out_dest[i]} == '0,
               "rst_fields", {out_data[i], out_tid[i], out_dest[i]}, 128'd0);
      end
      check(drop0 == 32'd0, "rst_drop0", 128'(drop0), 128'd0);
      check(drop1 == 2'd0, "rst_drop1", 128'(drop1), 128'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check(in_ready[0] && in_ready[1], "tready_after_rst", {in_ready[0], in_ready[1]}, 128'h3);

      // 3-beat packet s=0x05 d=0x12: one-cycle latency, TIDs held on every beat
      check(out_valid[0] == 1'b0, "lat_idle", 128'(out_valid[0]), 128'd0);
      cur_fwd[0] = 1'b1;
      for (int b = 0; b < 3; b++) begin
         bd[b] = {$urandom, $urandom};
         bk[b] = KW'($urandom);
         bu[b] = UW'($urandom);
         if (b == 0) begin
            bd[b][7:0]  = 8'h05;
            bd[b][15:8] = 8'h12;
         end
         push_exp(0, {bd[b], bk[b], bu[b], (b == 2), 8'h05, 8'h12});
      end
      send_beat(0, bd[0], bk[0], bu[0], 1'b0);
      check(out_valid[0] && out_tid[0] == 8'h05 && out_dest[0] == 8'h12, "lat_first",
            {out_valid[0], out_tid[0], out_dest[0]}, {1'b1, 8'h05, 8'h12});
      send_beat(0, bd[1], bk[1], bu[1], 1'b0);
      send_beat(0, bd[2], bk[2], bu[2], 1'b1);
      drain(0);

      // Back-to-back single-beat packets, one per cycle
      o = out_cnt[0];
      c = cyc;
      for (int i = 0; i < 16; i++) send_packet(0, 8'(8'hA0 + i), 8'(i), 1, 1'b0);
      check(cyc - c == 16, "stream_rate", 128'(cyc - c), 128'd16);
      drain(0);
      check(out_cnt[0] - o == 16, "stream_count", 128'(out_cnt[0] - o), 128'd16);

      // Filter table on the filtered instance
      for (int i = 0; i < 10; i++) begin
         o = out_cnt[1];
         c = cyc;
         send_packet(1, 8'h3C, tbl[i].d, tbl[i].nbeats, 1'b0);
         check(cyc - c == tbl[i].cycles, "filter_accept_rate", 128'(cyc - c), 128'(tbl[i].cycles));
         drain(1);
         check(out_cnt[1] - o == tbl[i].fwd_beats, "filter_fwd_beats", 128'(out_cnt[1] - o), 128'(tbl[i].fwd_beats));
         check(int'(drop1) == tbl[i].drop, "filter_drop_count", 128'(drop1), 128'(tbl[i].drop));
      end

      // Randomized streams with random downstream backpressure
      for (int sel = 0; sel < 2; sel++) begin
         beats = 0;
         rnd_mode[sel] = 1'b1;
         while (beats < 64) begin
            n  = $urandom_range(1, 4);
            dd = (sel == 0) ? 8'($urandom) : 8'($urandom_range(12, 23));
            send_packet(sel, 8'($urandom), dd, n, 1'b1);
            beats += n;
         end
         rnd_mode[sel]  = 1'b0;
         fix_ready[sel] = 1'b1;
         drain(sel);
      end
      check(int'(drop1) == exp_drop1, "random_drop_count", 128'(drop1), 128'(exp_drop1));

      // Reset in the middle of a 4-beat packet
      fix_ready[0] = 1'b0;
      @(posedge clk);
      #1;
      cur_fwd[0] = 1'b1;
      send_beat(0, {48'h0, 8'h22, 8'h11}, '1, 16'h0, 1'b0);
      send_beat(0, {$urandom, $urandom}, '1, 16'h0, 1'b0);
      check(out_valid[0] == 1'b1, "pre_rst_valid", 128'(out_valid[0]), 128'd1);
      rst_n = 1'b0;
      #1;
      check(out_valid[0] == 1'b0, "rst_mid_tvalid", 128'(out_valid[0]), 128'd0);
      check(out_tid[0] == 8'h0 && out_dest[0] == 8'h0, "rst_mid_tids", {out_tid[0], out_dest[0]}, 128'd0);
      check(in_ready[0] == 1'b0, "rst_mid_tready", 128'(in_ready[0]), 128'd0);
      check(drop1 == 2'd0, "rst_mid_drop", 128'(drop1), 128'd0);
      exp_q0.delete();
      exp_q1.delete();
      exp_drop1 = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      fix_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      check(in_ready[0] == 1'b1, "tready_rise", 128'(in_ready[0]), 128'd1);
      bd[0] = {$urandom, $urandom};
      bd[0][7:0]  = 8'h44;
      bd[0][15:8] = 8'h33;
      push_exp(0, {bd[0], 8'hFF, 16'h1234, 1'b1, 8'h44, 8'h33});
      send_beat(0, bd[0], 8'hFF, 16'h1234, 1'b1);
      check(out_valid[0] && out_tid[0] == 8'h44 && out_dest[0] == 8'h33, "post_rst_header",
            {out_valid[0], out_tid[0], out_dest[0]}, {1'b1, 8'h44, 8'h33});
      drain(0);

      check(drop0 == 32'd0, "nofilter_drop_count", 128'(drop0), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
